note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
Melody source placed directly upstream of the 7-segment note display. It steps through a fixed song table and drives the 12-bit `freq` bus read by the display and the tone generator.
- Each table entry holds a note index and a duration in beats.
- Each note sounds for its duration, then a short silent gap separates it from the next note.
- Start, stop and loop controls come from debounced board buttons/switches.

Parameters:
BEAT_CYCLES, 12500000, clk cycles per beat (0.25 s at 50 MHz); must be > GAP_CYCLES
GAP_CYCLES, 500000, silent clk cycles inserted after every step (10 ms)
SONG_LEN, 8, number of entries in the song table (>= 2)

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begin or restart the song at step 0
stop  input  1  single-cycle pulse; abort playback
loop  input  1  level; 1 = wrap to step 0 after last step instead of finishing
freq  output  12  note frequency in Hz; 0 = silence; consumed by display and tone generator
playing  output  1  high in PLAY and GAP states
note_start  output  1  one-cycle pulse on the first cycle of each step's PLAY phase
step  output  $clog2(SONG_LEN)  current table index
done  output  1  one-cycle pulse when a non-looping song completes

Behaviour:
- Reset (async, rst_n=0): state=IDLE, freq=0, playing=0, note_start=0, step=0, done=0, counters=0. This takes effect immediately and applies mid-song as well.
- Note ROM, 4-bit index to Hz:
  - 0..11 = 261,277,293,311,330,349,370,392,415,440,466,494 (C..B).
  - 12..15 = 0 (rest).
- Song table, entries as (index, beats), steps 0..7: (0,1) (2,1) (4,1) (5,1) (7,2) (9,2) (11,4) (12,1). Total 13 beats.
- Duration field: 2 bits encoding 1..4 beats (stored value + 1).
- States:
  - IDLE: freq=0, playing=0.
  - PLAY: freq=ROM[index[step]].
  - GAP: freq=0.
- IDLE to PLAY: on start. Next cycle step=0, freq=261, playing=1, note_start=1. Latency from start is 1 cycle.
- PLAY: a cycle counter runs beats*BEAT_CYCLES cycles, then the block moves to GAP.
  - freq is stable for exactly beats*BEAT_CYCLES cycles.
  - A rest entry still occupies PLAY for its full duration with freq=0.
- GAP: lasts exactly GAP_CYCLES cycles, then:
  - step < SONG_LEN-1: step+1, back to PLAY, note_start pulses.
  - step = SONG_LEN-1 and loop=1: step=0, PLAY, note_start pulses; no done pulse.
  - step = SONG_LEN-1 and loop=0: IDLE, step=0, done=1 for one cycle, playing=0.
- loop is sampled only on the last GAP cycle of the last step.
- stop in any state: IDLE next cycle, freq=0, step=0, counters cleared. No done pulse.
- start while PLAY or GAP: restart at step 0 (same as the IDLE start), note_start pulses.
- start and stop in the same cycle: stop wins.
- All outputs are registered; freq never glitches between steps.
- Counter width: $clog2(4*BEAT_CYCLES+1) bits; no wrap permitted within a step.

Decomposition:
- Package synth_pkg:
  - note index typedef (4 bits).
  - NOTE_REST = 12.
  - 12 NOTE_*_HZ localparams matching the display decode values.
  - Sequencer state enum {IDLE, PLAY, GAP}.
- Sub-module beat_timer:
  - Loadable down-counter with `load`, `load_value` and `expire` outputs.
  - Reused for both PLAY and GAP durations.
- Song table: a case-based ROM inside note_sequencer.

Test Plan:
All scenarios use BEAT_CYCLES=10, GAP_CYCLES=2.
1. start pulse in IDLE -> next cycle: freq=261, playing=1, note_start=1. freq=261 holds 10 cycles, then freq=0 for 2 cycles, then freq=293 with note_start=1.
2. Step 4 (G, 2 beats) -> freq=392 for exactly 20 cycles. Step 6 (B) -> 494 for 40 cycles. Step 7 -> freq=0 for 10+2 cycles.
3. loop=0, full song -> done pulses exactly 146 cycles after the first PLAY cycle (130 play + 16 gap). playing=0, freq=0, step=0 afterwards.
4. loop=1 -> after step 7 gap, freq=261, step=0, note_start=1, done stays 0. Clear loop mid-second pass -> song ends normally after step 7.
5. stop during step 3 PLAY -> next cycle: IDLE, freq=0, playing=0, no done. start and stop in the same cycle during step 2 -> IDLE.
6. start during step 5 -> restart at freq=261, step=0. rst_n low mid-GAP -> all outputs 0 immediately (asynchronous), IDLE after release.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared note/tone definitions: note index type, note frequency ROM, sequencer states.
// Frequencies match the decode table used by the 7-segment note display.
package synth_pkg;

   typedef logic [3:0] note_idx_t;

   localparam note_idx_t NOTE_REST = 4'd12;

   localparam logic [11:0] NOTE_C_HZ  = 12'd261;
   localparam logic [11:0] NOTE_CS_HZ = 12'd277;
   localparam logic [11:0] NOTE_D_HZ  = 12'd293;
   localparam logic [11:0] NOTE_DS_HZ = 12'd311;
   localparam logic [11:0] NOTE_E_HZ  = 12'd330;
   localparam logic [11:0] NOTE_F_HZ  = 12'd349;
   localparam logic [11:0] NOTE_FS_HZ = 12'd370;
   localparam logic [11:0] NOTE_G_HZ  = 12'd392;
   localparam logic [11:0] NOTE_GS_HZ = 12'd415;
   localparam logic [11:0] NOTE_A_HZ  = 12'd440;
   localparam logic [11:0] NOTE_AS_HZ = 12'd466;
   localparam logic [11:0] NOTE_B_HZ  = 12'd494;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } seq_state_t;

   // Duration is stored as beats-1 so 2 bits cover 1..4 beats.
   typedef struct packed {
      note_idx_t  idx;
      logic [1:0] beats_m1;
   } song_entry_t;

   function automatic logic [11:0] note_hz(input note_idx_t idx);
      case (idx)
         4'd0:    note_hz = NOTE_C_HZ;
         4'd1:    note_hz = NOTE_CS_HZ;
         4'd2:    note_hz = NOTE_D_HZ;
         4'd3:    note_hz = NOTE_DS_HZ;
         4'd4:    note_hz = NOTE_E_HZ;
         4'd5:    note_hz = NOTE_F_HZ;
         4'd6:    note_hz = NOTE_FS_HZ;
         4'd7:    note_hz = NOTE_G_HZ;
         4'd8:    note_hz = NOTE_GS_HZ;
         4'd9:    note_hz = NOTE_A_HZ;
         4'd10:   note_hz = NOTE_AS_HZ;
         4'd11:   note_hz = NOTE_B_HZ;
         default: note_hz = 12'd0;
      endcase
   endfunction

endpackage

// File: rtl/beat_timer.sv
// Loadable down-counter timing PLAY and GAP phases; expire_o marks the last cycle of a phase.
// A load of N yields N cycles before the phase ends; clear_i parks the counter at zero.
module beat_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] load_value_i,
   output logic         expire_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = load_value_i;
      end else if (count_q != '0) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/note_sequencer.sv
// Steps a fixed song table and drives the registered freq bus for display and tone generator.
// Start-to-first-note latency is one cycle; stop dominates start; all outputs registered.
module note_sequencer
   import synth_pkg::*;
#(
   parameter int BEAT_CYCLES = 12500000,
   parameter int GAP_CYCLES  = 500000,
   parameter int SONG_LEN    = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        stop,
   input  logic                        loop,
   output logic [11:0]                 freq,
   output logic                        playing,
   output logic                        note_start,
   output logic [$clog2(SONG_LEN)-1:0] step,
   output logic                        done
);

   localparam int SW = $clog2(SONG_LEN);
   localparam int CW = $clog2(4 * BEAT_CYCLES + 1);
   localparam logic [SW-1:0] LAST_STEP = SW'(SONG_LEN - 1);

   function automatic song_entry_t song_rom(input logic [SW-1:0] s);
      case (int'(s))
         0:       song_rom = '{idx: 4'd0,  beats_m1: 2'd0};
         1:       song_rom = '{idx: 4'd2,  beats_m1: 2'd0};
         2:       song_rom = '{idx: 4'd4,  beats_m1: 2'd0};
         3:       song_rom = '{idx: 4'd5,  beats_m1: 2'd0};
         4:       song_rom = '{idx: 4'd7,  beats_m1: 2'd1};
         5:       song_rom = '{idx: 4'd9,  beats_m1: 2'd1};
         6:       song_rom = '{idx: 4'd11, beats_m1: 2'd3};
         7:       song_rom = '{idx: NOTE_REST, beats_m1: 2'd0};
         default: song_rom = '{idx: NOTE_REST, beats_m1: 2'd0};
      endcase
   endfunction

   function automatic logic [CW-1:0] play_cycles(input song_entry_t e);
      play_cycles = CW'((int'(e.beats_m1) + 1) * BEAT_CYCLES);
   endfunction

   seq_state_t    state_q, state_d;
   logic [SW-1:0] step_q, step_d;
   logic [11:0]   freq_q, freq_d;
   logic          playing_q, playing_d;
   logic          note_start_q, note_start_d;
   logic          done_q, done_d;

   logic          enter_play;
   logic          finish;
   logic          tmr_load;
   logic          tmr_clear;
   logic [CW-1:0] tmr_value;
   logic          tmr_expire;

   beat_timer #(.W(CW)) u_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (tmr_load),
      .clear_i      (tmr_clear),
      .load_value_i (tmr_value),
      .expire_o     (tmr_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         step_q       <= '0;
         freq_q       <= '0;
         playing_q    <= 1'b0;
         note_start_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         freq_q       <= freq_d;
         playing_q    <= playing_d;
         note_start_q <= note_start_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      tmr_load   = 1'b0;
      tmr_clear  = 1'b0;
      tmr_value  = '0;
      enter_play = 1'b0;
      finish     = 1'b0;
      if (stop) begin
         state_d   = IDLE;
         step_d    = '0;
         tmr_clear = 1'b1;
      end else if (start) begin
         state_d    = PLAY;
         step_d     = '0;
         enter_play = 1'b1;
      end else begin
         case (state_q)
            PLAY: begin
               if (tmr_expire) begin
                  state_d   = GAP;
                  tmr_load  = 1'b1;
                  tmr_value = CW'(GAP_CYCLES);
               end
            end
            GAP: begin
               if (tmr_expire) begin
                  if (step_q != LAST_STEP) begin
                     state_d    = PLAY;
                     step_d     = step_q + SW'(1);
                     enter_play = 1'b1;
                  end else if (loop) begin
                     state_d    = PLAY;
                     step_d     = '0;
                     enter_play = 1'b1;
                  end else begin
                     state_d   = IDLE;
                     step_d    = '0;
                     finish    = 1'b1;
                     tmr_clear = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
      // Every entry into PLAY reloads the timer with the new step's duration.
      if (enter_play) begin
         tmr_load  = 1'b1;
         tmr_value = play_cycles(song_rom(step_d));
      end
   end

   always_comb begin
      freq_d       = (state_d == PLAY) ? note_hz(song_rom(step_d).idx) : 12'd0;
      playing_d    = (state_d != IDLE);
      note_start_d = enter_play;
      done_d       = finish;
   end

   assign freq       = freq_q;
   assign playing    = playing_q;
   assign note_start = note_start_q;
   assign step       = step_q;
   assign done       = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with BEAT_CYCLES=10, GAP_CYCLES=2.
// Cycle 0 below is the first PLAY cycle after a start pulse.
module tb_note_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop = 1'b0;
   logic [11:0] freq;
   logic        playing;
   logic        note_start;
   logic [2:0]  step;
   logic        done;

   int tests = 0;
   int failed = 0;

   note_sequencer #(.BEAT_CYCLES(10), .GAP_CYCLES(2), .SONG_LEN(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .loop       (loop),
      .freq       (freq),
      .playing    (playing),
      .note_start (note_start),
      .step       (step),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int at;
      int freq;
      int playing;
      int ns;
      int step;
      int done;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs[NV];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input int f, input int p, input int ns,
                             input int s, input int d);
      check({tag, ".freq"}, int'(freq), f);
      check({tag, ".playing"}, int'(playing), p);
      check({tag, ".note_start"}, int'(note_start), ns);
      check({tag, ".step"}, int'(step), s);
      check({tag, ".done"}, int'(done), d);
   endtask

   task automatic advance(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns at the negedge of the first PLAY cycle (cycle 0).
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int vi, spurious, n261, n392, n494, nrest7, cyc, done_at, quiet;

      vecs[0]  = '{0,   261, 1, 1, 0, 0};
      vecs[1]  = '{9,   261, 1, 0, 0, 0};
      vecs[2]  = '{10,  0,   1, 0, 0, 0};
      vecs[3]  = '{11,  0,   1, 0, 0, 0};
      vecs[4]  = '{12,  293, 1, 1, 1, 0};
      vecs[5]  = '{48,  392, 1, 1, 4, 0};
      vecs[6]  = '{67,  392, 1, 0, 4, 0};
      vecs[7]  = '{68,  0,   1, 0, 4, 0};
      vecs[8]  = '{92,  494, 1, 1, 6, 0};
      vecs[9]  = '{131, 494, 1, 0, 6, 0};
      vecs[10] = '{132, 0,   1, 0, 6, 0};
      vecs[11] = '{134, 0,   1, 1, 7, 0};
      vecs[12] = '{145, 0,   1, 0, 7, 0};
      vecs[13] = '{146, 0,   0, 0, 0, 1};
      vecs[14] = '{147, 0,   0, 0, 0, 0};

      // Reset state
      advance(2);
      check_outs("reset", 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      advance(2);
      check_outs("idle", 0, 0, 0, 0, 0);

      // Full song, loop=0
      pulse_start();
      vi = 0; spurious = 0; n261 = 0; n392 = 0; n494 = 0; nrest7 = 0;
      for (int c = 0; c <= 150; c++) begin
         if (vi < NV && vecs[vi].at == c) begin
            check_outs($sformatf("song_c%0d", c), vecs[vi].freq, vecs[vi].playing,
                       vecs[vi].ns, vecs[vi].step, vecs[vi].done);
            vi++;
         end
         if (c != 146 && done) spurious++;
         if (freq == 12'd261) n261++;
         if (freq == 12'd392) n392++;
         if (freq == 12'd494) n494++;
         if (step == 3'd7 && freq == 12'd0 && playing) nrest7++;
         @(negedge clk);
      end
      check("song_done_spurious", spurious, 0);
      check("c_len", n261, 10);
      check("g_len", n392, 20);
      check("b_len", n494, 40);
      check("rest7_len", nrest7, 12);

      // Looping: wrap without done, then clear loop mid second pass
      loop = 1'b1;
      pulse_start();
      spurious = 0;
      for (int c = 0; c < 146; c++) begin
         if (done) spurious++;
         @(negedge clk);
      end
      check_outs("wrap", 261, 1, 1, 0, 0);
      check("wrap_done_spurious", spurious, 0);
      advance(50);
      loop = 1'b0;
      cyc = 196; done_at = -1;
      while (cyc < 400 && done_at < 0) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) done_at = cyc;
      end
      check("loop_end_done_cycle", done_at, 292);
      @(negedge clk);
      check_outs("loop_end_idle", 0, 0, 0, 0, 0);

      // Stop during step 3 PLAY
      pulse_start();
      advance(40);
      check("stop_pre_step", int'(step), 3);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check_outs("stop", 0, 0, 0, 0, 0);
      quiet = 0;
      for (int c = 0; c < 20; c++) begin
         if (done || playing || freq != 12'd0) quiet++;
         @(negedge clk);
      end
      check("stop_quiet", quiet, 0);

      // start and stop together during step 2
      pulse_start();
      advance(26);
      check("both_pre_step", int'(step), 2);
      start = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      check_outs("both", 0, 0, 0, 0, 0);

      // Restart during step 5
      pulse_start();
      advance(75);
      check("restart_pre_freq", int'(freq), 440);
      check("restart_pre_step", int'(step), 5);
      pulse_start();
      check_outs("restart", 261, 1, 1, 0, 0);

      // Asynchronous reset in the step 1 gap
      advance(22);
      check_outs("pre_rst_gap", 0, 1, 0, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("async_rst", 0, 0, 0, 0, 0);
      advance(2);
      rst_n = 1'b1;
      advance(3);
      check_outs("post_rst", 0, 0, 0, 0, 0);
      pulse_start();
      check_outs("post_rst_start", 261, 1, 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
